// File: rtl/vga_timing_pkg.sv
// Shared timing constants for the VGA raster generator (640x480@60 defaults)
// and the sync polarity helper.
package vga_timing_pkg;

  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_H_FP     = 16;
  localparam int unsigned DEF_H_SYNC   = 96;
  localparam int unsigned DEF_H_BP     = 48;
  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_FP     = 10;
  localparam int unsigned DEF_V_SYNC   = 2;
  localparam int unsigned DEF_V_BP     = 33;

  localparam int unsigned H_TOTAL  = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int unsigned V_TOTAL  = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
  localparam int unsigned HS_START = DEF_H_ACTIVE + DEF_H_FP;
  localparam int unsigned HS_END   = HS_START + DEF_H_SYNC;
  localparam int unsigned VS_START = DEF_V_ACTIVE + DEF_V_FP;
  localparam int unsigned VS_END   = VS_START + DEF_V_SYNC;

  // Line level for a sync pulse, given polarity and whether the pulse is asserted.
  function automatic logic sync_level(input logic active_high, input logic asserted);
    return ~(asserted ^ active_high);
  endfunction

endpackage

// File: rtl/vga_timing_gen_raster_counter.sv
// Wrap counter used for both raster axes; exposes its next value so the
// parent can register decode outputs in step with the count.
module raster_counter #(
  parameter int unsigned Total = 800,
  parameter int unsigned Width = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [Width-1:0] value,
  output logic [Width-1:0] value_next,
  output logic             wrap_next
);

  localparam logic [Width-1:0] Last = Width'(Total - 1);

  logic [Width-1:0] value_q, value_d;

  // >= rather than == so an out-of-range count recovers on the next advance.
  always_comb begin
    wrap_next = en && (value_q >= Last);
    value_d   = value_q;
    if (wrap_next) begin
      value_d = '0;
    end else if (en) begin
      value_d = value_q + Width'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_q <= Last;
    end else begin
      value_q <= value_d;
    end
  end

  assign value      = value_q;
  assign value_next = value_d;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing source: counters, active-video, syncs, line/frame markers
// and a frame counter, every output taken directly from a flop.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE         = DEF_H_ACTIVE,
  parameter int unsigned H_FP             = DEF_H_FP,
  parameter int unsigned H_SYNC           = DEF_H_SYNC,
  parameter int unsigned H_BP             = DEF_H_BP,
  parameter int unsigned V_ACTIVE         = DEF_V_ACTIVE,
  parameter int unsigned V_FP             = DEF_V_FP,
  parameter int unsigned V_SYNC           = DEF_V_SYNC,
  parameter int unsigned V_BP             = DEF_V_BP,
  parameter bit          SYNC_ACTIVE_HIGH = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pix_en,
  output logic [9:0] pix_x,
  output logic [9:0] pix_y,
  output logic       video_active,
  output logic       hsync,
  output logic       vsync,
  output logic       line_start,
  output logic       frame_start,
  output logic [7:0] frame_count
);

  localparam int unsigned HTotal = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned VTotal = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (HTotal > 1024 || VTotal > 1024) begin : g_total_check
    $error("vga_timing_gen: horizontal and vertical totals must not exceed 1024");
  end

  // 11-bit compares so bounds of exactly 1024 stay representable.
  localparam logic [10:0] HActive = 11'(H_ACTIVE);
  localparam logic [10:0] HsStart = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HsEnd   = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] VActive = 11'(V_ACTIVE);
  localparam logic [10:0] VsStart = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VsEnd   = 11'(V_ACTIVE + V_FP + V_SYNC);

  localparam logic SyncIdle = sync_level(SYNC_ACTIVE_HIGH, 1'b0);

  logic [9:0] h_next, v_next;
  logic       h_wrap, v_wrap, v_en;

  logic       video_active_q, video_active_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       line_start_q, line_start_d;
  logic       frame_start_q, frame_start_d;
  logic [7:0] frame_count_q, frame_count_d;

  assign v_en = pix_en & h_wrap;

  raster_counter #(
    .Total(HTotal),
    .Width(10)
  ) u_h_cnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (pix_en),
    .value     (pix_x),
    .value_next(h_next),
    .wrap_next (h_wrap)
  );

  raster_counter #(
    .Total(VTotal),
    .Width(10)
  ) u_v_cnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (v_en),
    .value     (pix_y),
    .value_next(v_next),
    .wrap_next (v_wrap)
  );

  // Decode the next raster position so every flop lands aligned with the counters.
  always_comb begin
    video_active_d = ({1'b0, h_next} < HActive) && ({1'b0, v_next} < VActive);
    hsync_d        = sync_level(SYNC_ACTIVE_HIGH,
                                ({1'b0, h_next} >= HsStart) && ({1'b0, h_next} < HsEnd));
    vsync_d        = sync_level(SYNC_ACTIVE_HIGH,
                                ({1'b0, v_next} >= VsStart) && ({1'b0, v_next} < VsEnd));
    line_start_d   = h_wrap;
    frame_start_d  = v_wrap;
    frame_count_d  = frame_count_q + {7'd0, v_wrap};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      video_active_q <= 1'b0;
      hsync_q        <= SyncIdle;
      vsync_q        <= SyncIdle;
      line_start_q   <= 1'b0;
      frame_start_q  <= 1'b0;
      frame_count_q  <= 8'd0;
    end else begin
      video_active_q <= video_active_d;
      hsync_q        <= hsync_d;
      vsync_q        <= vsync_d;
      line_start_q   <= line_start_d;
      frame_start_q  <= frame_start_d;
      frame_count_q  <= frame_count_d;
    end
  end

  assign video_active = video_active_q;
  assign hsync        = hsync_q;
  assign vsync        = vsync_q;
  assign line_start   = line_start_q;
  assign frame_start  = frame_start_q;
  assign frame_count  = frame_count_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default 640x480 build for reset/line/stall behaviour, plus
// two tiny builds (opposite sync polarity) for whole-frame and counter checks.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Default-parameter DUT
  logic       rst_n_d, pix_en_d;
  logic [9:0] pix_x, pix_y;
  logic       video_active, hsync, vsync, line_start, frame_start;
  logic [7:0] frame_count;

  // Small builds: H 4/1/1/1 (total 7), V 2/1/1/1 (total 5)
  logic       rst_n_s, pix_en_s;
  logic [9:0] pix_x_s, pix_y_s, pix_x_h, pix_y_h;
  logic       video_active_s, hsync_s, vsync_s, line_start_s, frame_start_s;
  logic       video_active_h, hsync_h, vsync_h, line_start_h, frame_start_h;
  logic [7:0] frame_count_s, frame_count_h;

  vga_timing_gen dut (
    .clk(clk), .rst_n(rst_n_d), .pix_en(pix_en_d),
    .pix_x(pix_x), .pix_y(pix_y), .video_active(video_active),
    .hsync(hsync), .vsync(vsync), .line_start(line_start),
    .frame_start(frame_start), .frame_count(frame_count)
  );

  vga_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
    .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1), .SYNC_ACTIVE_HIGH(1'b0)
  ) dut_s (
    .clk(clk), .rst_n(rst_n_s), .pix_en(pix_en_s),
    .pix_x(pix_x_s), .pix_y(pix_y_s), .video_active(video_active_s),
    .hsync(hsync_s), .vsync(vsync_s), .line_start(line_start_s),
    .frame_start(frame_start_s), .frame_count(frame_count_s)
  );

  vga_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
    .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1), .SYNC_ACTIVE_HIGH(1'b1)
  ) dut_h (
    .clk(clk), .rst_n(rst_n_s), .pix_en(pix_en_s),
    .pix_x(pix_x_h), .pix_y(pix_y_h), .video_active(video_active_h),
    .hsync(hsync_h), .vsync(vsync_h), .line_start(line_start_h),
    .frame_start(frame_start_h), .frame_count(frame_count_h)
  );

  logic [9:0] mx, my;
  logic [7:0] exp_fc;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic advance_model;
    if (mx == 10'd6) begin
      mx = 10'd0;
      my = (my == 10'd4) ? 10'd0 : my + 10'd1;
    end else begin
      mx = mx + 10'd1;
    end
  endtask

  task automatic test_reset;
    repeat (2) tick;
    checks++;
    if ({pix_x, pix_y, frame_count} !== {10'd799, 10'd524, 8'd0}) begin
      errors++;
      $display("FAIL reset_counters: got x=%0d y=%0d fc=%0d, want x=799 y=524 fc=0",
               pix_x, pix_y, frame_count);
    end
    checks++;
    if ({video_active, hsync, vsync, line_start, frame_start} !== 5'b01100) begin
      errors++;
      $display("FAIL reset_flags: got act/hs/vs/ls/fs=%b, want 01100",
               {video_active, hsync, vsync, line_start, frame_start});
    end
    rst_n_d = 1'b1;
    tick;
    checks++;
    if ({pix_x, pix_y, video_active, line_start, frame_start, frame_count} !==
        {10'd0, 10'd0, 3'b111, 8'd1}) begin
      errors++;
      $display("FAIL first_clk: got x=%0d y=%0d act=%b ls=%b fs=%b fc=%0d, want 0 0 1 1 1 1",
               pix_x, pix_y, video_active, line_start, frame_start, frame_count);
    end
    tick;
    checks++;
    if ({pix_x, line_start, frame_start, frame_count} !== {10'd1, 2'b00, 8'd1}) begin
      errors++;
      $display("FAIL pulse_clear: got x=%0d ls=%b fs=%b fc=%0d, want x=1 ls=0 fs=0 fc=1",
               pix_x, line_start, frame_start, frame_count);
    end
  endtask

  task automatic test_line;
    int last_ls = -1, period = 0, run = 0, low_len = 0, fall_x = -1, rise_x = -1;
    logic prev_hs;
    prev_hs = hsync;
    for (int i = 0; i < 1600; i++) begin
      tick;
      if (line_start) begin
        if (last_ls >= 0) period = i - last_ls;
        last_ls = i;
      end
      if (prev_hs && !hsync) fall_x = int'(pix_x);
      if (!hsync) run++;
      if (!prev_hs && hsync) begin
        rise_x  = int'(pix_x);
        low_len = run;
        run     = 0;
      end
      prev_hs = hsync;
    end
    checks++;
    if (period !== 800) begin
      errors++;
      $display("FAIL line_period: got %0d clks, want 800", period);
    end
    checks++;
    if (fall_x !== 656) begin
      errors++;
      $display("FAIL hsync_fall_x: got %0d, want 656", fall_x);
    end
    checks++;
    if (rise_x !== 752) begin
      errors++;
      $display("FAIL hsync_rise_x: got %0d, want 752", rise_x);
    end
    checks++;
    if (low_len !== 96) begin
      errors++;
      $display("FAIL hsync_width: got %0d clks, want 96", low_len);
    end
  endtask

  task automatic test_pix_en_toggle;
    int last_ls = -1, period = 0, ls_cnt = 0, hold_err = 0, wide_err = 0;
    logic [30:0] snap;
    logic prev_ls;
    for (int i = 0; i < 3200; i++) begin
      pix_en_d = i[0];
      snap     = {pix_x, pix_y, video_active, hsync, vsync, frame_count};
      prev_ls  = line_start;
      tick;
      if (!pix_en_d) begin
        if (snap !== {pix_x, pix_y, video_active, hsync, vsync, frame_count}) hold_err++;
        if (line_start) hold_err++;
      end
      if (line_start && prev_ls) wide_err++;
      if (line_start) begin
        ls_cnt++;
        if (last_ls >= 0) period = i - last_ls;
        last_ls = i;
      end
    end
    pix_en_d = 1'b1;
    checks++;
    if (period !== 1600) begin
      errors++;
      $display("FAIL stall_line_period: got %0d clks, want 1600", period);
    end
    checks++;
    if (ls_cnt !== 2) begin
      errors++;
      $display("FAIL stall_line_count: got %0d pulses, want 2", ls_cnt);
    end
    checks++;
    if (hold_err !== 0) begin
      errors++;
      $display("FAIL stall_hold: got %0d cycles changed, want 0", hold_err);
    end
    checks++;
    if (wide_err !== 0) begin
      errors++;
      $display("FAIL stall_pulse_width: got %0d wide pulses, want 0", wide_err);
    end
  endtask

  task automatic test_async_reset;
    repeat (299) tick;
    checks++;
    if ({pix_x, pix_y} !== {10'd300, 10'd4}) begin
      errors++;
      $display("FAIL pre_reset_pos: got x=%0d y=%0d, want x=300 y=4", pix_x, pix_y);
    end
    #3;
    rst_n_d = 1'b0;
    #1;
    checks++;
    if ({pix_x, pix_y, frame_count, video_active, hsync, vsync, line_start} !==
        {10'd799, 10'd524, 8'd0, 4'b0110}) begin
      errors++;
      $display("FAIL async_reset: got x=%0d y=%0d fc=%0d act=%b hs=%b vs=%b ls=%b, want 799 524 0 0 1 1 0",
               pix_x, pix_y, frame_count, video_active, hsync, vsync, line_start);
    end
    tick;
    rst_n_d = 1'b1;
    tick;
    checks++;
    if ({pix_x, pix_y, frame_start, frame_count} !== {10'd0, 10'd0, 1'b1, 8'd1}) begin
      errors++;
      $display("FAIL restart: got x=%0d y=%0d fs=%b fc=%0d, want 0 0 1 1",
               pix_x, pix_y, frame_start, frame_count);
    end
  endtask

  task automatic test_small_frame;
    int pos_err = 0, act_cnt = 0, vs_low = 0, vs_rise = 0, vs_pos_err = 0;
    int hs_low = 0, hs_err = 0, pol_err = 0, fs_cnt = 0;
    logic act_a = 1'b0, act_b = 1'b1, act_c = 1'b1, prev_vs;
    tick;
    checks++;
    if ({pix_x_s, pix_y_s, hsync_s, vsync_s, hsync_h, vsync_h} !== {10'd6, 10'd4, 4'b1100}) begin
      errors++;
      $display("FAIL small_reset: got x=%0d y=%0d hs/vs=%b%b hs_h/vs_h=%b%b, want 6 4 11 00",
               pix_x_s, pix_y_s, hsync_s, vsync_s, hsync_h, vsync_h);
    end
    rst_n_s = 1'b1;
    mx = 10'd6;
    my = 10'd4;
    prev_vs = vsync_s;
    for (int i = 0; i < 35; i++) begin
      tick;
      advance_model;
      if ({pix_x_s, pix_y_s} !== {mx, my}) pos_err++;
      if (video_active_s) act_cnt++;
      if (mx == 10'd3 && my == 10'd1) act_a = video_active_s;
      if (mx == 10'd4 && my == 10'd0) act_b = video_active_s;
      if (mx == 10'd0 && my == 10'd2) act_c = video_active_s;
      if (!vsync_s) begin
        vs_low++;
        if (my != 10'd3) vs_pos_err++;
      end
      if (!prev_vs && vsync_s) begin
        vs_rise++;
        if (mx != 10'd0 || my != 10'd4) vs_pos_err++;
      end
      if (!hsync_s) begin
        hs_low++;
        if (mx != 10'd5) hs_err++;
      end
      if (frame_start_s) begin
        fs_cnt++;
        if (mx != 10'd0 || my != 10'd0 || frame_count_s !== 8'd1) pos_err++;
      end
      if (hsync_h !== ~hsync_s || vsync_h !== ~vsync_s ||
          {pix_x_h, pix_y_h, video_active_h, line_start_h, frame_start_h} !==
          {pix_x_s, pix_y_s, video_active_s, line_start_s, frame_start_s}) pol_err++;
      prev_vs = vsync_s;
    end
    checks++;
    if (pos_err !== 0 || fs_cnt !== 1) begin
      errors++;
      $display("FAIL small_raster: got %0d position errors and %0d frame pulses, want 0 and 1",
               pos_err, fs_cnt);
    end
    checks++;
    if (act_cnt !== 8) begin
      errors++;
      $display("FAIL small_active_count: got %0d, want 8", act_cnt);
    end
    checks++;
    if ({act_a, act_b, act_c} !== 3'b100) begin
      errors++;
      $display("FAIL small_active_corners: got (3,1)(4,0)(0,2)=%b, want 100", {act_a, act_b, act_c});
    end
    checks++;
    if (vs_low !== 7 || vs_rise !== 1 || vs_pos_err !== 0) begin
      errors++;
      $display("FAIL small_vsync: got low=%0d rises=%0d misplaced=%0d, want 7 1 0",
               vs_low, vs_rise, vs_pos_err);
    end
    checks++;
    if (hs_low !== 5 || hs_err !== 0) begin
      errors++;
      $display("FAIL small_hsync: got low=%0d misplaced=%0d, want 5 0", hs_low, hs_err);
    end
    checks++;
    if (pol_err !== 0) begin
      errors++;
      $display("FAIL sync_polarity: got %0d cycles differing, want 0", pol_err);
    end
  endtask

  task automatic test_frame_count;
    int frames = 0, seq_err = 0, pair_err = 0;
    exp_fc = 8'd1;
    for (int i = 0; i < 255 * 35; i++) begin
      tick;
      advance_model;
      if (frame_start_s) begin
        frames++;
        exp_fc = exp_fc + 8'd1;
        if (frame_count_s !== exp_fc || mx != 10'd0 || my != 10'd0) seq_err++;
      end
      if (frame_count_h !== frame_count_s) pair_err++;
    end
    checks++;
    if (frames !== 255) begin
      errors++;
      $display("FAIL fc_frames: got %0d frame pulses, want 255", frames);
    end
    checks++;
    if (seq_err !== 0) begin
      errors++;
      $display("FAIL fc_sequence: got %0d out-of-sequence frames, want 0", seq_err);
    end
    checks++;
    if (frame_count_s !== 8'd0) begin
      errors++;
      $display("FAIL fc_wrap: got %0d after 256 frames, want 0", frame_count_s);
    end
    checks++;
    if (pair_err !== 0) begin
      errors++;
      $display("FAIL fc_polarity_builds: got %0d cycles differing, want 0", pair_err);
    end
  endtask

  initial begin
    rst_n_d  = 1'b1;
    rst_n_s  = 1'b1;
    pix_en_d = 1'b1;
    pix_en_s = 1'b1;
    #2;
    rst_n_d = 1'b0;
    rst_n_s = 1'b0;
    test_reset;
    test_line;
    test_pix_en_toggle;
    test_async_reset;
    test_small_frame;
    test_frame_count;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
